// File: rtl/audio_pwm_out.sv
// Audio pin driver: latches one generator sample per PWM period, attenuates, offsets and emits PWM.
// Define AUDIO_SIGMADELTA_EN to swap the PWM comparator for a first-order sigma-delta modulator.
module audio_pwm_out #(
    parameter int PWM_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  volume,
    input  logic [31:0] romdata,
    output logic        pwm_out,
    output logic        sample_strobe,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    state_t              state;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_new;
    logic [PWM_BITS-1:0] cnt_inc;
    logic                wrap;
    logic                unused_hi;

    // Attenuate by arithmetic shift, flip to offset binary, keep the top PWM_BITS bits.
    function automatic logic [PWM_BITS-1:0] to_duty(input logic [15:0] sample,
                                                    input logic [3:0]  shift);
        logic signed [15:0] s;
        logic [15:0]        u;
        s = $signed(sample) >>> shift;
        u = s ^ 16'h8000;
        return PWM_BITS'(u >> (16 - PWM_BITS));
    endfunction

    assign duty_new  = to_duty(romdata[15:0], volume);
    assign cnt_inc   = cnt + 1'b1;
    assign wrap      = (cnt == CNT_MAX);
    assign unused_hi = ^romdata[31:16];

`ifdef AUDIO_SIGMADELTA_EN
    logic [PWM_BITS:0] acc;
    logic [PWM_BITS:0] acc_next;
    assign acc_next = {1'b0, acc[PWM_BITS-1:0]} + {1'b0, duty_q};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            duty_q        <= '0;
            pwm_out       <= 1'b0;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
`ifdef AUDIO_SIGMADELTA_EN
            acc           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt           <= '0;
                    pwm_out       <= 1'b0;
                    sample_strobe <= 1'b0;
                    if (enable) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        sample_strobe <= 1'b1;
                        duty_q        <= duty_new;
`ifndef AUDIO_SIGMADELTA_EN
                        pwm_out       <= (duty_new != '0);
`endif
                    end
                end
                RUN, DRAIN: begin
                    // Only a draining period that reaches its last cycle may stop.
                    if (state == DRAIN && wrap && !enable) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        pwm_out       <= 1'b0;
                        sample_strobe <= 1'b0;
                        busy          <= 1'b0;
`ifdef AUDIO_SIGMADELTA_EN
                        acc           <= '0;
`endif
                    end else begin
                        state         <= enable ? RUN : DRAIN;
                        cnt           <= cnt_inc;
                        sample_strobe <= wrap;
                        if (wrap) begin
                            duty_q <= duty_new;
                        end
`ifdef AUDIO_SIGMADELTA_EN
                        acc     <= acc_next;
                        pwm_out <= acc_next[PWM_BITS];
`else
                        // Compare against the duty that will be live in the next cycle.
                        pwm_out <= wrap ? (duty_new != '0) : (cnt_inc < duty_q);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Randomised bench for audio_pwm_out: per-period waveform checked against an arithmetic model.
module tb_audio_pwm_out;

    localparam int PWM_BITS = 10;
    localparam int PER      = 1 << PWM_BITS;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  volume;
    logic [31:0] romdata;
    logic        pwm_out;
    logic        sample_strobe;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_pwm_out #(.PWM_BITS(PWM_BITS)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .volume        (volume),
        .romdata       (romdata),
        .pwm_out       (pwm_out),
        .sample_strobe (sample_strobe),
        .busy          (busy)
    );

    // Floor-divide the signed sample by 2^vol, offset by half scale, scale to PWM_BITS.
    function automatic int ref_duty(input logic [31:0] rd, input int vol);
        logic [15:0] lo;
        int x, d, s;
        lo = rd[15:0];
        x  = int'($signed(lo));
        d  = 1 << vol;
        if (x >= 0) s = x / d;
        else        s = -((-x + d - 1) / d);
        return (s + 32768) >> (16 - PWM_BITS);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            checks++;
            if ({busy, pwm_out, sample_strobe} !== 3'b000) begin
                errors++;
                $display("FAIL %s idle cyc %0d busy/pwm/strobe got %b%b%b want 000",
                         tag, i, busy, pwm_out, sample_strobe);
            end
            step();
        end
    endtask

    // Checks one full period starting at its strobe cycle; cont reports whether another period follows.
    task automatic run_period(input int duty, input logic [31:0] rd_next, input int vol_next,
                              input int drop_at, input int raise_at, input string tag,
                              output bit cont);
        bit en_a, en_b;
        logic exp_p, exp_s;
        en_a = 1'b0;
        en_b = 1'b0;
        for (int k = 0; k < PER; k++) begin
            exp_p = (k < duty);
            exp_s = (k == 0);
            checks++;
            if (pwm_out !== exp_p) begin
                errors++;
                $display("FAIL %s pwm k=%0d got %b want %b (duty %0d)", tag, k, pwm_out, exp_p, duty);
            end
            checks++;
            if (sample_strobe !== exp_s) begin
                errors++;
                $display("FAIL %s strobe k=%0d got %b want %b", tag, k, sample_strobe, exp_s);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy k=%0d got %b want 1", tag, k, busy);
            end
            if (k == drop_at)  enable = 1'b0;
            if (k == raise_at) enable = 1'b1;
            if (k == PER / 3) begin
                romdata = $urandom;
                volume  = 4'($urandom_range(0, 15));
            end
            if (k == PER - 1) begin
                romdata = rd_next;
                volume  = 4'(vol_next);
            end
            if (k == PER - 2) en_a = enable;
            if (k == PER - 1) en_b = enable;
            step();
        end
        // A new period starts if enable was seen high at either of the last two edges.
        cont = en_a | en_b;
    endtask

    task automatic start(input logic [31:0] rd, input int vol, input string tag);
        romdata = rd;
        volume  = 4'(vol);
        enable  = 1'b1;
        step();
        checks++;
        if (sample_strobe !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start latency strobe/busy got %b%b want 11", tag, sample_strobe, busy);
        end
    endtask

    task automatic expect_cont(input bit cont, input bit want, input string tag);
        if (!want && cont) begin
            errors++;
            $display("FAIL %s model expected stop got continue", tag);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        volume  = 4'd0;
        romdata = 32'h0000_7FFF;
        step();
        step();
        checks++;
        if ({busy, pwm_out, sample_strobe} !== 3'b000) begin
            errors++;
            $display("FAIL reset outputs got %b%b%b want 000", busy, pwm_out, sample_strobe);
        end
        reset  = 1'b0;
        enable = 1'b0;
        step();
        check_idle(4, "reset");
    endtask

    task automatic test_directed();
        bit c;
        start(32'h0000_7FFF, 0, "dir");
        run_period(ref_duty(32'h0000_7FFF, 0), 32'h0000_8000, 0, -1, -1, "full", c);
        run_period(ref_duty(32'h0000_8000, 0), 32'h0000_0000, 0, -1, -1, "zero", c);
        run_period(ref_duty(32'h0000_0000, 0), 32'hABCD_7FFF, 1, -1, -1, "mid", c);
        run_period(ref_duty(32'hABCD_7FFF, 1), 32'h0000_0000, 15, 300, -1, "vol1", c);
        expect_cont(c, 1'b0, "vol1");
        check_idle(5, "drain");
    endtask

    task automatic test_random();
        bit c;
        logic [31:0] rd, rd_n;
        int v, v_n;
        rd = $urandom;
        v  = $urandom_range(0, 15);
        start(rd, v, "rand");
        for (int p = 0; p < 6; p++) begin
            rd_n = $urandom;
            v_n  = $urandom_range(0, 15);
            run_period(ref_duty(rd, v), rd_n, v_n, -1, -1, "rand", c);
            rd = rd_n;
            v  = v_n;
        end
        run_period(ref_duty(rd, v), 32'h0, 0, 100, -1, "rand_end", c);
        expect_cont(c, 1'b0, "rand_end");
        check_idle(3, "rand_end");
    endtask

    task automatic test_back_to_back();
        bit c;
        logic [31:0] rd2, rd3;
        int v2, v3;
        rd2 = $urandom;
        v2  = $urandom_range(0, 3);
        rd3 = $urandom;
        v3  = $urandom_range(0, 15);
        start(32'h0000_4000, 0, "b2b");
        // Drop then re-raise inside the period: next period follows with no gap.
        run_period(ref_duty(32'h0000_4000, 0), rd2, v2, 300, 600, "resume", c);
        // Drop exactly on the wrap edge: one more full period runs before idling.
        run_period(ref_duty(rd2, v2), rd3, v3, PER - 1, -1, "wrapdrop", c);
        run_period(ref_duty(rd3, v3), 32'h0, 0, -1, -1, "lastper", c);
        expect_cont(c, 1'b0, "lastper");
        check_idle(5, "b2b");
    endtask

    task automatic test_reset_mid();
        start(32'h0000_7FFF, 0, "rstmid");
        for (int k = 0; k < 500; k++) step();
        checks++;
        if (pwm_out !== 1'b1) begin
            errors++;
            $display("FAIL rstmid pwm before reset got %b want 1", pwm_out);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({busy, pwm_out, sample_strobe} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid outputs got %b%b%b want 000", busy, pwm_out, sample_strobe);
        end
        reset  = 1'b0;
        enable = 1'b0;
        check_idle(3, "rstmid");
        start(32'h0000_0000, 0, "rstmid_restart");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
